axi_lite_master_v1_0: RTL

//  AXI4-lite initiator that turns a simple command/response stream into single-beat AXI4-lite

---
 rtl/axi_lite_master_v1_0_if.sv | 47 ++++
 rtl/axi_lite_master_v1_0.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_v1_0_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_v1_0_if
// Brief    : AXI4-lite bus bundle with master/slave modports (32-bit data).
// Revision : 1.0  initial release
// ============================================================================
interface axi_lite_master_v1_0_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 4
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]                    AWPROT;
  logic                          AWVALID;
  logic                          AWREADY;
  logic [31:0]                   WDATA;
  logic [3:0]                    WSTRB;
  logic                          WVALID;
  logic                          WREADY;
  logic [1:0]                    BRESP;
  logic                          BVALID;
  logic                          BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]                    ARPROT;
  logic                          ARVALID;
  logic                          ARREADY;
  logic [31:0]                   RDATA;
  logic [1:0]                    RRESP;
  logic                          RVALID;
  logic                          RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master_v1_0.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_v1_0
// Brief    : Command/response stream to single-beat AXI4-lite initiator.
//            Optional saturating statistics under AXI_MASTER_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module axi_lite_master_v1_0 #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_STAT_WIDTH       = 16
) (
  input  wire                          M_AXI_ACLK,
  input  wire                          M_AXI_ARESETN,
  input  wire                          cmd_valid,
  output logic                         cmd_ready,
  input  wire                          cmd_write,
  input  wire [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  wire [31:0]                   cmd_wdata,
  input  wire [3:0]                    cmd_wstrb,
  output logic                         rsp_valid,
  input  wire                          rsp_ready,
  output logic                         rsp_write,
  output logic [31:0]                  rsp_rdata,
  output logic [1:0]                   rsp_resp,
  axi_lite_master_v1_0_if.master       m_axi
`ifdef AXI_MASTER_STATS_EN
  ,
  output logic [C_STAT_WIDTH-1:0]      stat_wr_cnt,
  output logic [C_STAT_WIDTH-1:0]      stat_rd_cnt,
  output logic [C_STAT_WIDTH-1:0]      stat_err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic                          cmd_ready_q, cmd_ready_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          rsp_write_q, rsp_write_d;
  logic [31:0]                   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;

`ifdef AXI_MASTER_STATS_EN
  logic [C_STAT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [C_STAT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [C_STAT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Saturate at all-ones instead of wrapping.
  function automatic logic [C_STAT_WIDTH-1:0] sat_inc(input logic [C_STAT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(C_STAT_WIDTH-1){1'b0}}, 1'b1};
  endfunction
`else
  logic [C_STAT_WIDTH-1:0] unused_stat_width;
  assign unused_stat_width = '0;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_write) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end
      S_WR: begin
        // Address and data channels retire independently, in any order.
        if (m_axi.AWREADY) awvalid_d = 1'b0;
        if (m_axi.WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (m_axi.BVALID) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = m_axi.BRESP;
        end
      end
      S_RADDR: begin
        if (m_axi.ARREADY) begin
          state_d   = S_RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RDATA: begin
        if (m_axi.RVALID) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi.RDATA;
          rsp_resp_d  = m_axi.RRESP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);

`ifdef AXI_MASTER_STATS_EN
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q != S_RSP && state_d == S_RSP) begin
      if (rsp_write_d) wr_cnt_d = sat_inc(wr_cnt_q);
      else             rd_cnt_d = sat_inc(rd_cnt_q);
      if (rsp_resp_d != 2'b00) err_cnt_d = sat_inc(err_cnt_q);
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_resp_q  <= 2'b00;
`ifdef AXI_MASTER_STATS_EN
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_MASTER_STATS_EN
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi.AWADDR  = awaddr_q;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = wstrb_q;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;
  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;

`ifdef AXI_MASTER_STATS_EN
  assign stat_wr_cnt  = wr_cnt_q;
  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
